logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  WIDTH-bit pipelined logic unit for the ALU datapath. It is the parametrised
//  successor to the 1-bit and_2/or_2/xor_2/not_1/nand_2/nor_2 gates.
//  Selects one of 8 bitwise ops per transaction and adds zero/parity flags.
//  Has an accumulator mode that chains results. Valid/ready on both sides,
//  2-stage pipeline, full throughput of 1 op/cycle.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=1)
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      reset, synchronous, active-low
//  in_valid   in   1      upstream transaction valid
//  in_ready   out  1      unit can accept; transfer when in_valid&in_ready
//  op         in   3      000 AND, 001 OR, 010 XOR, 011 NOT a, 100 NAND,
//                         101 NOR, 110 XNOR, 111 PASS a
//  use_acc    in   1      1: replace operand a with acc at compute time
//  acc_clr    in   1      clear acc to 0; takes priority over acc update
//  a          in   WIDTH  operand a
//  b          in   WIDTH  operand b (ignored by NOT, PASS)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts; transfer when out_valid&out_ready
//  y          out  WIDTH  result
//  zero       out  1      y == 0
//  parity     out  1      ^y (odd parity of result)
//  acc        out  WIDTH  accumulator = result of most recent computed op
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): s1_valid, s2_valid, out_valid, y, zero, parity,
//    and acc all go to 0. in_ready reads 1 once reset is released.
//    Any in-flight transaction is discarded.
//  Stage S1 registers {op, use_acc, a, b} on the accept edge.
//  Stage S2 registers y/zero/parity, computed from S1, on the S1->S2 edge.
//    out_valid = s2_valid.
//  Advance rules:
//    s2_free  = !s2_valid | out_ready
//    s1_move  = s1_valid & s2_free
//    in_ready = !s1_valid | s1_move   (combinational)
//  Latency: accept at edge N gives out_valid=1 after edge N+1 if there is no
//    backpressure. Back-to-back accepts yield back-to-back outputs.
//  Backpressure: while out_valid=1 and out_ready=0, y/zero/parity/out_valid
//    hold stable. S1 holds; in_ready=0 once S1 is full. No loss, no duplication.
//  Accumulator:
//    - Operand a_eff = use_acc ? acc : S1.a.
//    - On each s1_move edge, acc <= computed result.
//    - So use_acc on back-to-back transactions chains on the previous result,
//      with no bubble.
//    - acc_clr=1 at any edge forces acc=0, overriding a same-edge update.
//      The result in flight is unaffected.
//    - acc_clr is not tied to the handshake.
//  Arithmetic: all ops are bitwise over WIDTH bits; no carry, no overflow.
//    NOT and PASS use a_eff.
//  Simultaneous events:
//    - Accept and output transfer on the same edge are legal. S1 and S2 move
//      together.
//    - Reset dominates every other input.
// TESTING
//  1 Exhaustive 1-bit check (WIDTH=1): all 8 ops x a,b in {0,1}, with
//    out_ready=1. y matches the truth table; zero=!y; parity=y.
//  2 Latency (WIDTH=8): accept a=8'hF0, b=8'h3C, op=XOR at edge N.
//    After edge N+1: out_valid=1, y=8'hCC, zero=0, parity=0.
//  3 Backpressure: stream 4 ops with out_ready=0 for 5 cycles. in_ready drops
//    after 2 accepts; y is held stable. Release: 4 results appear in order,
//    none lost or duplicated.
//  4 Accumulator chain: (a=8'h0F, b=8'hF0, OR) -> 8'hFF. Then use_acc,
//    b=8'h55, AND -> 8'h55. Then use_acc, NOT -> 8'hAA. Final acc=8'hAA.
//  5 acc_clr on the same edge as a compute: acc=0, y still shows the result.
//    A following use_acc with OR, b=8'h01 gives y=8'h01.
//  6 Reset mid-stream with both stages full: out_valid=0, acc=0, y=0 on the
//    next edge. No stale result emerges after reset is released.
//  Plus: random a/b/op/ready run vs reference model, >=1000 transactions.

Source files
------------

// File: rtl/logic_unit_if.sv
// Valid/ready request and result bundle for the pipelined logic unit.
interface logic_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             use_acc;
    logic             acc_clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic [WIDTH-1:0] acc;

    // Requester / result consumer side
    modport master (
        output in_valid, op, use_acc, acc_clr, a, b, out_ready,
        input  in_ready, out_valid, y, zero, parity, acc
    );

    // Logic unit side
    modport slave (
        input  in_valid, op, use_acc, acc_clr, a, b, out_ready,
        output in_ready, out_valid, y, zero, parity, acc
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage WIDTH-bit bitwise logic unit with zero/parity flags and a
// chaining accumulator; valid/ready on both sides, one op per cycle.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    logic_unit_if.slave  bus
);
    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic             use_acc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    s1_t              s1_q,       s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q,        y_d;
    logic             zero_q,     zero_d;
    logic             parity_q,   parity_d;
    logic [WIDTH-1:0] acc_q,      acc_d;

    logic             s2_free_c;
    logic             s1_move_c;
    logic             in_ready_c;
    logic             accept_c;
    logic [WIDTH-1:0] a_eff_c;
    logic [WIDTH-1:0] res_c;

    // Handshake, operand selection, bitwise op and next-state for both stages
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        zero_d     = zero_q;
        parity_d   = parity_q;
        acc_d      = acc_q;
        res_c      = '0;

        s2_free_c  = !s2_valid_q || bus.out_ready;
        s1_move_c  = s1_valid_q && s2_free_c;
        in_ready_c = !s1_valid_q || s1_move_c;
        accept_c   = bus.in_valid && in_ready_c;

        // Accumulator substitution lets back-to-back ops chain without a bubble
        a_eff_c = s1_q.use_acc ? acc_q : s1_q.a;

        case (op_e'(s1_q.op))
            OP_AND:  res_c = a_eff_c & s1_q.b;
            OP_OR:   res_c = a_eff_c | s1_q.b;
            OP_XOR:  res_c = a_eff_c ^ s1_q.b;
            OP_NOT:  res_c = ~a_eff_c;
            OP_NAND: res_c = ~(a_eff_c & s1_q.b);
            OP_NOR:  res_c = ~(a_eff_c | s1_q.b);
            OP_XNOR: res_c = ~(a_eff_c ^ s1_q.b);
            OP_PASS: res_c = a_eff_c;
            default: res_c = '0;
        endcase

        // Output stage drains on transfer, refills from S1 on a move
        if (s1_move_c) begin
            s2_valid_d = 1'b1;
            y_d        = res_c;
            zero_d     = (res_c == '0);
            parity_d   = ^res_c;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end

        // Input stage captures on accept, empties when its entry moves on
        if (accept_c) begin
            s1_valid_d = 1'b1;
            s1_d       = '{op: bus.op, use_acc: bus.use_acc, a: bus.a, b: bus.b};
        end else if (s1_move_c) begin
            s1_valid_d = 1'b0;
        end

        // Clear wins over a same-edge update; the in-flight result is untouched
        if (bus.acc_clr) begin
            acc_d = '0;
        end else if (s1_move_c) begin
            acc_d = res_c;
        end
    end

    // Pipeline and accumulator registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            zero_q     <= 1'b0;
            parity_q   <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            zero_q     <= zero_d;
            parity_q   <= parity_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = s2_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.acc       = acc_q;
endmodule
